// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access sizes and FSM states.
package mem_pkg;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} mstate_t;

endpackage

// File: rtl/store_lane_align.sv
// Steers right-justified store data onto big-endian byte lanes and flags
// accesses that are misaligned or use the reserved size code.
module store_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] lane_data,
  output logic [3:0]  byte_en,
  output logic        misalign
);

  // Byte 0 of the word lives in [31:24], so lane selection counts down from the MSB.
  always_comb begin
    lane_data = wdata;
    byte_en   = 4'b0000;
    misalign  = 1'b0;
    case (size_t'(size))
      SZ_BYTE: begin
        lane_data = {4{wdata[7:0]}};
        byte_en   = 4'b1000 >> addr_lo;
      end
      SZ_HALF: begin
        lane_data = {2{wdata[15:0]}};
        byte_en   = addr_lo[1] ? 4'b0011 : 4'b1100;
        misalign  = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
    if (misalign) byte_en = 4'b0000;
  end

endmodule

// File: rtl/mem_responder.sv
// Word-organised data memory for the multicycle MIPS core: req/ack handshake
// with programmable wait states, byte-enabled big-endian stores, aligned-word loads.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW          = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mstate_t     state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [1:0]  size_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [0:(1<<AW)-1];

  logic          use_live, commit;
  logic          cur_we;
  logic [1:0]    cur_size;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] idx;
  logic [31:0]   lane_data;
  logic [3:0]    byte_en;
  logic          misalign;
  logic          addr_unused;

  assign addr_unused = ^addr[31:AW+2];

  // With zero wait states the access completes on the acceptance edge itself,
  // so the live inputs must drive the datapath while idle.
  assign use_live  = (state == S_IDLE);
  assign cur_we    = use_live ? we : we_q;
  assign cur_size  = use_live ? size : size_q;
  assign cur_addr  = use_live ? addr[AW+1:0] : addr_q;
  assign cur_wdata = use_live ? wdata : wdata_q;
  assign idx       = cur_addr[AW+1:2];

  assign commit = !reset &&
                  (((state == S_WAIT) && (cnt == 4'd0)) ||
                   ((WAIT_CYCLES == 0) && (state == S_IDLE) && req));

  store_lane_align u_align (
    .size      (cur_size),
    .addr_lo   (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .lane_data (lane_data),
    .byte_en   (byte_en),
    .misalign  (misalign)
  );

  // Handshake FSM; ack/err/rdata are registered on the edge entering RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            cnt     <= CNT_INIT;
            state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        ack <= 1'b1;
        err <= misalign;
        if (!cur_we && !misalign) rdata <= mem[idx];
      end
    end
  end

  // Array is deliberately not reset; only enabled lanes of a good store change.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT_CYCLES=2 instance for the bulk of
// the scenarios and a WAIT_CYCLES=0 instance for the zero-wait latency.
module tb_mem_responder;

  localparam int WAIT  = 2;
  localparam int LAT   = WAIT + 1;
  localparam int SPACE = WAIT + 2;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] rd;
  } txn_t;

  typedef struct {
    logic        e;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack, err;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [1:0]  size0 = 2'b10;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic        ack0, err0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_rd = 32'd0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  mem_responder #(.AW(6), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err)
  );

  mem_responder #(.AW(6), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .size(size0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0)
  );

  // Drives one request for a single cycle, scrambles the inputs afterwards and
  // waits (bounded) for ack; reports latency in cycles after acceptance.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic e,
                         output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = ~w; size = ~sz; addr = $urandom; wdata = $urandom;
    lat = 1;
    while (ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e  = err;
    rd = rdata;
  endtask

  function automatic exp_t expect_of(input txn_t t);
    exp_t x;
    x.e   = t.e;
    x.lat = LAT;
    x.rd  = (!t.w && !t.e) ? t.rd : last_rd;
    return x;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("[TB] FAIL reset ack: got %b expected 0", ack); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset err: got %b expected 0", err); end
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("[TB] FAIL reset rdata: got %h expected 0", rdata); end
    n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset ack0: got %b expected 0", ack0); end
    last_rd = 32'd0;
  endtask

  task automatic test_word();
    txn_t tbl[$];
    exp_t x;
    int lat;
    logic e;
    logic [31:0] rd;
    tbl.push_back('{1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF});
    foreach (tbl[i]) begin
      x = expect_of(tbl[i]);
      exp_q.push_back(x);
      last_rd = x.rd;
      run_txn(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, lat, e, rd);
      x = exp_q.pop_front();
      n_cmp++; if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL word[%0d] latency: got %0d expected %0d", i, lat, x.lat); end
      n_cmp++; if (e !== x.e) begin n_bad++; $display("[TB] FAIL word[%0d] err: got %b expected %b", i, e, x.e); end
      n_cmp++; if (rd !== x.rd) begin n_bad++; $display("[TB] FAIL word[%0d] rdata: got %h expected %h", i, rd, x.rd); end
    end
  endtask

  task automatic test_lanes();
    txn_t tbl[$];
    exp_t x;
    int lat;
    logic e;
    logic [31:0] rd;
    tbl.push_back('{1'b1, 2'b10, 32'h10,  32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 2'b00, 32'h11,  32'hFFFFFFA5, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10,  32'h0,        1'b0, 32'h11A53344});
    tbl.push_back('{1'b1, 2'b10, 32'h10,  32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 2'b01, 32'h12,  32'h1234BEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10,  32'h0,        1'b0, 32'h1122BEEF});
    tbl.push_back('{1'b1, 2'b10, 32'h10,  32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 2'b01, 32'h10,  32'h0000BEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 2'b00, 32'h13,  32'h00000077, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h110, 32'h0,        1'b0, 32'hBEEF3377});
    foreach (tbl[i]) begin
      x = expect_of(tbl[i]);
      exp_q.push_back(x);
      last_rd = x.rd;
      run_txn(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, lat, e, rd);
      x = exp_q.pop_front();
      n_cmp++; if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL lanes[%0d] latency: got %0d expected %0d", i, lat, x.lat); end
      n_cmp++; if (e !== x.e) begin n_bad++; $display("[TB] FAIL lanes[%0d] err: got %b expected %b", i, e, x.e); end
      n_cmp++; if (rd !== x.rd) begin n_bad++; $display("[TB] FAIL lanes[%0d] rdata: got %h expected %h", i, rd, x.rd); end
    end
  endtask

  task automatic test_misalign();
    txn_t tbl[$];
    exp_t x;
    int lat;
    logic e;
    logic [31:0] rd;
    tbl.push_back('{1'b1, 2'b10, 32'h10, 32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10, 32'h0,        1'b0, 32'h11223344});
    tbl.push_back('{1'b0, 2'b10, 32'h13, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b01, 32'h11, 32'h0000FFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b10, 32'h12, 32'h00000000, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b11, 32'h10, 32'h00000000, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 2'b11, 32'h14, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10, 32'h0,        1'b0, 32'h11223344});
    foreach (tbl[i]) begin
      x = expect_of(tbl[i]);
      exp_q.push_back(x);
      last_rd = x.rd;
      run_txn(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, lat, e, rd);
      x = exp_q.pop_front();
      n_cmp++; if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL misalign[%0d] latency: got %0d expected %0d", i, lat, x.lat); end
      n_cmp++; if (e !== x.e) begin n_bad++; $display("[TB] FAIL misalign[%0d] err: got %b expected %b", i, e, x.e); end
      n_cmp++; if (rd !== x.rd) begin n_bad++; $display("[TB] FAIL misalign[%0d] rdata: got %h expected %h", i, rd, x.rd); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int n = 0;
    int ack_cyc[3] = '{0, 0, 0};
    exp_t x;
    for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 32'h11223344, LAT});
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10; wdata = 32'h0;
    while (n < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack === 1'b1) begin
        ack_cyc[n] = cyc;
        if (n == 2) req = 1'b0;
        x = exp_q.pop_front();
        n_cmp++; if (rdata !== x.rd) begin n_bad++; $display("[TB] FAIL b2b[%0d] rdata: got %h expected %h", n, rdata, x.rd); end
        n_cmp++; if (err !== x.e) begin n_bad++; $display("[TB] FAIL b2b[%0d] err: got %b expected %b", n, err, x.e); end
        n++;
      end
    end
    req = 1'b0;
    last_rd = 32'h11223344;
    n_cmp++; if (n !== 3) begin n_bad++; $display("[TB] FAIL b2b ack count: got %0d expected 3", n); end
    n_cmp++; if (ack_cyc[0] !== LAT) begin n_bad++; $display("[TB] FAIL b2b first ack: got %0d expected %0d", ack_cyc[0], LAT); end
    n_cmp++; if (ack_cyc[1] - ack_cyc[0] !== SPACE) begin n_bad++; $display("[TB] FAIL b2b spacing0: got %0d expected %0d", ack_cyc[1] - ack_cyc[0], SPACE); end
    n_cmp++; if (ack_cyc[2] - ack_cyc[1] !== SPACE) begin n_bad++; $display("[TB] FAIL b2b spacing1: got %0d expected %0d", ack_cyc[2] - ack_cyc[1], SPACE); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int acks = 0;
    logic e;
    logic [31:0] rd;
    exp_t x;
    exp_q.push_back('{1'b0, last_rd, LAT});
    run_txn(1'b1, 2'b10, 32'h20, 32'h11223344, lat, e, rd);
    x = exp_q.pop_front();
    n_cmp++; if (e !== x.e) begin n_bad++; $display("[TB] FAIL rstmid setup err: got %b expected %b", e, x.e); end
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
      reset = 1'b0;
    end
    last_rd = 32'd0;
    n_cmp++; if (acks !== 0) begin n_bad++; $display("[TB] FAIL rstmid stray acks: got %0d expected 0", acks); end
    exp_q.push_back('{1'b0, 32'h11223344, LAT});
    run_txn(1'b0, 2'b10, 32'h20, 32'h0, lat, e, rd);
    x = exp_q.pop_front();
    last_rd = x.rd;
    n_cmp++; if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL rstmid latency: got %0d expected %0d", lat, x.lat); end
    n_cmp++; if (rd !== x.rd) begin n_bad++; $display("[TB] FAIL rstmid rdata: got %h expected %h", rd, x.rd); end
  endtask

  task automatic test_wait0();
    exp_t x;
    exp_q.push_back('{1'b0, 32'h0, 1});
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 32'h4; wdata0 = 32'h0BADC0DE;
    @(negedge clk);
    req0 = 1'b0; we0 = 1'b0; wdata0 = 32'h0;
    x = exp_q.pop_front();
    n_cmp++; if (ack0 !== 1'b1) begin n_bad++; $display("[TB] FAIL wait0 store ack: got %b expected 1", ack0); end
    n_cmp++; if (err0 !== x.e) begin n_bad++; $display("[TB] FAIL wait0 store err: got %b expected %b", err0, x.e); end
    @(negedge clk);
    n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("[TB] FAIL wait0 ack pulse: got %b expected 0", ack0); end
    exp_q.push_back('{1'b0, 32'h0BADC0DE, 1});
    req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 32'h4;
    @(negedge clk);
    req0 = 1'b0;
    x = exp_q.pop_front();
    n_cmp++; if (ack0 !== 1'b1) begin n_bad++; $display("[TB] FAIL wait0 load ack: got %b expected 1", ack0); end
    n_cmp++; if (rdata0 !== x.rd) begin n_bad++; $display("[TB] FAIL wait0 load rdata: got %h expected %h", rdata0, x.rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_wait0();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
